// File: rtl/dct_pkg.sv
// Shared definitions for the 8x8 transpose bank between the row and column
// 1-D DCT stages. The writer and the reader both import this package so
// that they agree on the matrix size, word width and address mapping.
//   N   : matrix dimension (rows = cols = N)
//   W   : data word width
//   AW  : bank word address width, log2(N*N)
//   CW  : row/column index width, log2(N)
package dct_pkg;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int AW = 6;
    localparam int CW = 3;

    // Reader controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Bank word address of element (row, col). The bank is always stored
    // row-major, so a transposed read only changes the counter order.
    function automatic logic [AW-1:0] addr(input logic [CW-1:0] row,
                                           input logic [CW-1:0] col);
        return AW'(row) * AW'(N) + AW'(col);
    endfunction

endpackage

// File: rtl/bank_rd_outreg.sv
// Output register for the transpose bank reader: one data word plus the
// column-last and frame-last markers, presented as a valid/ready stream.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   load                    : capture din and markers this cycle
//   din, col_last_in,
//   frm_last_in             : word and markers to capture
//   ready                   : downstream ready
//   dout, col_last, frm_last: registered word and markers
//   valid                   : dout holds a word not yet accepted
// A word is transferred on a rising edge where valid & ready are both 1.
// While valid & !ready the register holds dout and markers unchanged;
// the caller only asserts load when !valid | ready, so no word is lost.
module bank_rd_outreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         col_last_in,
    input  logic         frm_last_in,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         col_last,
    output logic         frm_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            valid    <= 1'b0;
            col_last <= 1'b0;
            frm_last <= 1'b0;
        end else if (load) begin
            dout     <= din;
            col_last <= col_last_in;
            frm_last <= frm_last_in;
            valid    <= 1'b1;
        end else if (ready) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/transpose_bank_reader.sv
// Read-side controller for the 8x8 transpose register bank. After the
// writer pulses bank_full it reads all N*N words (column-major when
// COL_MAJ=1, row-major otherwise), streams them out with column/frame
// markers and pulses bank_free as soon as the last word has been read.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bank_full      : writer pulse, bank holds a complete matrix
//   bank_free      : pulse, bank no longer read and may be overwritten
//   rd_addr, rd_en : bank read address (row*N+col) and read strobe
//   rd_data        : bank word, combinational from rd_addr
//   out_data, out_valid, out_ready : output word stream
//   out_col_last   : with out_valid, last word of a column (or row when COL_MAJ=0)
//   out_frm_last   : with out_valid, last word of the frame
//   busy           : controller not idle
//   state_dbg      : current FSM state (rd_state_t encoding)
// The N, W and AW parameters must match the dct_pkg constants, since the
// address mapping comes from the shared package.
module transpose_bank_reader #(
    parameter int N       = 8,
    parameter int W       = 16,
    parameter int AW      = 6,
    parameter int COL_MAJ = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bank_full,
    output logic          bank_free,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic [W-1:0]  rd_data,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_col_last,
    output logic          out_frm_last,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    import dct_pkg::*;

    localparam int              IW       = $clog2(N);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

    rd_state_t     state_q, state_d;
    logic          pending_q, pending_d;
    logic [IW-1:0] row_q, col_q;
    logic          advance;
    logic          last_word;
    logic          col_last_w;
    logic          enter_read;

    // The output register can take a new word when empty or being drained.
    assign advance    = !out_valid || out_ready;
    assign last_word  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign col_last_w = (COL_MAJ != 0) ? (row_q == LAST_IDX) : (col_q == LAST_IDX);
    assign rd_addr    = addr(row_q, col_q);
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bank_full || pending_q) state_d = READ;
            end
            READ: begin
                rd_en = advance;
                if (advance && last_word) state_d = DRAIN;
            end
            DRAIN: begin
                // Only the final word can be in the register here.
                if (out_valid && out_ready)
                    state_d = (bank_full || pending_q) ? READ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One-deep memory of a bank_full that arrives while busy. A request
    // that starts READ this cycle consumes it; extra pulses are dropped.
    assign enter_read = (state_d == READ) && (state_q != READ);

    always_comb begin
        pending_d = pending_q;
        if (enter_read)
            pending_d = 1'b0;
        else if (bank_full && (state_q != IDLE))
            pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            bank_free <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            bank_free <= rd_en && last_word;
        end
    end

    // Inner index steps every read; both orders end on (N-1, N-1) and
    // wrap back to (0, 0), so addresses never leave the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (rd_en) begin
            if (COL_MAJ != 0) begin
                if (row_q == LAST_IDX) begin
                    row_q <= '0;
                    col_q <= (col_q == LAST_IDX) ? '0 : col_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                if (col_q == LAST_IDX) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    bank_rd_outreg #(.W(W)) u_outreg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (rd_en),
        .din         (rd_data),
        .col_last_in (col_last_w),
        .frm_last_in (last_word),
        .ready       (out_ready),
        .dout        (out_data),
        .valid       (out_valid),
        .col_last    (out_col_last),
        .frm_last    (out_frm_last)
    );

endmodule

// File: tb/tb_transpose_bank_reader.sv
module tb_transpose_bank_reader;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int AW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- column-major DUT ----------------
  logic          bank_full = 1'b0;
  logic          out_ready = 1'b0;
  logic          bank_free, rd_en, out_valid, out_col_last, out_frm_last, busy;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data, out_data;
  logic [1:0]    state_dbg;

  // bank model: word[a] = a*3
  assign rd_data = W'(rd_addr) * W'(3);

  transpose_bank_reader #(.N(N), .W(W), .AW(AW), .COL_MAJ(1)) dut (
    .clk(clk), .rst_n(rst_n), .bank_full(bank_full), .bank_free(bank_free),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_col_last(out_col_last),
    .out_frm_last(out_frm_last), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- row-major DUT ----------------
  logic          rm_full = 1'b0;
  logic          rm_ready = 1'b1;
  logic          rm_free, rm_rd_en, rm_valid, rm_col_last, rm_frm_last, rm_busy;
  logic [AW-1:0] rm_rd_addr;
  logic [W-1:0]  rm_rd_data, rm_data;
  logic [1:0]    rm_state;

  assign rm_rd_data = W'(rm_rd_addr) * W'(3);

  transpose_bank_reader #(.N(N), .W(W), .AW(AW), .COL_MAJ(0)) dut_rm (
    .clk(clk), .rst_n(rst_n), .bank_full(rm_full), .bank_free(rm_free),
    .rd_addr(rm_rd_addr), .rd_en(rm_rd_en), .rd_data(rm_rd_data), .out_data(rm_data),
    .out_valid(rm_valid), .out_ready(rm_ready), .out_col_last(rm_col_last),
    .out_frm_last(rm_frm_last), .busy(rm_busy), .state_dbg(rm_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_data[$];
  logic         got_col[$];
  logic         got_frm[$];
  int           got_cyc[$];
  int           free_cnt = 0;
  int           rd_cnt = 0;

  // Accepted words are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_col.push_back(out_col_last);
        got_frm.push_back(out_frm_last);
        got_cyc.push_back(cyc);
      end
      if (bank_free) free_cnt++;
      if (rd_en) rd_cnt++;
    end
  end

  // Expected k-th word of a column-major stream: col=k/8, row=k%8, addr=row*8+col.
  function automatic logic [W-1:0] exp_cm(int k);
    int kk;
    int a;
    kk = k % (N * N);
    a = (kk % N) * N + (kk / N);
    return W'(a * 3);
  endfunction

  task automatic clear_mon();
    got_data.delete(); got_col.delete(); got_frm.delete(); got_cyc.delete();
    free_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic fill_exp(int frames);
    exp_q.delete();
    for (int k = 0; k < frames * N * N; k++) exp_q.push_back(exp_cm(k));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_full();
    @(posedge clk); #1 bank_full = 1'b1;
    @(posedge clk); #1 bank_full = 1'b0;
  endtask

  task automatic wait_words(int n, int budget, string tag);
    int c;
    c = 0;
    while (got_data.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (got_data.size() < n) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d words, required %0d", tag, got_data.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if ({rd_en, out_valid, bank_free, busy, out_col_last, out_frm_last, rd_addr, out_data, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b v=%b free=%b busy=%b cl=%b fl=%b addr=%0d data=%0d st=%0d, required all 0",
               rd_en, out_valid, bank_free, busy, out_col_last, out_frm_last, rd_addr, out_data, state_dbg);
    end
    n_cmp++;
    if ({rm_rd_en, rm_valid, rm_free, rm_busy, rm_rd_addr, rm_data} !== '0) begin
      n_err++;
      $display("FAIL reset_rm_outputs: got en=%b v=%b free=%b busy=%b addr=%0d data=%0d, required all 0",
               rm_rd_en, rm_valid, rm_free, rm_busy, rm_rd_addr, rm_data);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b rd_en=%b, required 0 0", busy, rd_en);
    end
  endtask

  task automatic test_full_rate();
    clear_mon();
    fill_exp(1);
    out_ready = 1'b1;
    pulse_full();
    // The cycle after bank_full: first read at address 0, nothing valid yet.
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== '0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL t1_latency: got rd_en=%b addr=%0d valid=%b, required 1 0 0", rd_en, rd_addr, out_valid);
    end
    wait_words(64, 200, "t1");
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < got_data.size() && k < 64; k++) begin
      n_cmp++;
      if (got_data[k] !== exp_q[k] || got_col[k] !== ((k % 8) == 7) || got_frm[k] !== (k == 63)) begin
        n_err++;
        $display("FAIL t1_word[%0d]: got data=%0d cl=%b fl=%b, required data=%0d cl=%b fl=%b",
                 k, got_data[k], got_col[k], got_frm[k], exp_q[k], (k % 8) == 7, k == 63);
      end
    end
    n_cmp++;
    if (got_data.size() !== 64 || free_cnt !== 1 || rd_cnt !== 64 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_counts: got words=%0d free=%0d reads=%0d busy=%b, required 64 1 64 0",
               got_data.size(), free_cnt, rd_cnt, busy);
    end
    n_cmp++;
    if (got_data.size() == 64 && (got_cyc[63] - got_cyc[0]) !== 63) begin
      n_err++;
      $display("FAIL t1_throughput: got span=%0d cycles, required 63", got_cyc[63] - got_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    int c;
    bit stalled;
    clear_mon();
    fill_exp(1);
    c = 0;
    stalled = 0;
    out_ready = 1'b1;
    pulse_full();
    while (got_data.size() < 64 && c < 600) begin
      if (!stalled && got_data.size() == 10) begin
        // Word 10 (addr 17, data 51) waits; the next read is addr 25.
        stalled = 1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== 16'd51 || rd_en !== 1'b0 || rd_addr !== 6'd25) begin
            n_err++;
            $display("FAIL t2_stall: got valid=%b data=%0d rd_en=%b addr=%0d, required 1 51 0 25",
                     out_valid, out_data, rd_en, rd_addr);
          end
          @(posedge clk); #1;
        end
      end else begin
        out_ready = ((c % 2) == 0);
        @(posedge clk); #1;
        c++;
      end
    end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < got_data.size() && k < 64; k++) begin
      n_cmp++;
      if (got_data[k] !== exp_q[k] || got_col[k] !== ((k % 8) == 7) || got_frm[k] !== (k == 63)) begin
        n_err++;
        $display("FAIL t2_word[%0d]: got data=%0d cl=%b fl=%b, required data=%0d cl=%b fl=%b",
                 k, got_data[k], got_col[k], got_frm[k], exp_q[k], (k % 8) == 7, k == 63);
      end
    end
    n_cmp++;
    if (got_data.size() !== 64 || free_cnt !== 1 || rd_cnt !== 64 || stalled !== 1'b1) begin
      n_err++;
      $display("FAIL t2_counts: got words=%0d free=%0d reads=%0d stalled=%b, required 64 1 64 1",
               got_data.size(), free_cnt, rd_cnt, stalled);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    fill_exp(2);
    out_ready = 1'b1;
    pulse_full();                      // frame 1 starts
    repeat (18) @(posedge clk);
    pulse_full();                      // ~cycle 20: held as pending
    repeat (10) @(posedge clk);
    pulse_full();                      // pending already set: dropped
    wait_words(128, 400, "t3");
    repeat (100) @(posedge clk);
    #1;
    for (int k = 0; k < got_data.size() && k < 128; k++) begin
      n_cmp++;
      if (got_data[k] !== exp_q[k] || got_col[k] !== ((k % 8) == 7) || got_frm[k] !== ((k % 64) == 63)) begin
        n_err++;
        $display("FAIL t3_word[%0d]: got data=%0d cl=%b fl=%b, required data=%0d cl=%b fl=%b",
                 k, got_data[k], got_col[k], got_frm[k], exp_q[k], (k % 8) == 7, (k % 64) == 63);
      end
    end
    n_cmp++;
    if (got_data.size() !== 128 || free_cnt !== 2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL t3_counts: got words=%0d free=%0d busy=%b, required 128 2 0", got_data.size(), free_cnt, busy);
    end
    // Frame 2 is read right after DRAIN hands over: accepts are 2 cycles apart, no idle state.
    n_cmp++;
    if (got_data.size() >= 65 && (got_cyc[64] - got_cyc[63]) !== 2) begin
      n_err++;
      $display("FAIL t3_gap: got %0d cycles between words 63 and 64, required 2", got_cyc[64] - got_cyc[63]);
    end
  endtask

  task automatic test_drain_coincide();
    int c;
    clear_mon();
    fill_exp(2);
    out_ready = 1'b1;
    pulse_full();
    c = 0;
    while (bank_free !== 1'b1 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (bank_free !== 1'b1 || state_dbg !== 2'd2) begin
      n_err++;
      $display("FAIL t6_drain: got bank_free=%b state=%0d, required 1 2", bank_free, state_dbg);
    end
    bank_full = 1'b1;
    @(posedge clk); #1 bank_full = 1'b0;
    n_cmp++;
    if (state_dbg !== 2'd1 || rd_en !== 1'b1 || rd_addr !== '0) begin
      n_err++;
      $display("FAIL t6_restart: got state=%0d rd_en=%b addr=%0d, required 1 1 0", state_dbg, rd_en, rd_addr);
    end
    wait_words(128, 300, "t6");
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < got_data.size() && k < 128; k++) begin
      n_cmp++;
      if (got_data[k] !== exp_q[k] || got_col[k] !== ((k % 8) == 7) || got_frm[k] !== ((k % 64) == 63)) begin
        n_err++;
        $display("FAIL t6_word[%0d]: got data=%0d cl=%b fl=%b, required data=%0d cl=%b fl=%b",
                 k, got_data[k], got_col[k], got_frm[k], exp_q[k], (k % 8) == 7, (k % 64) == 63);
      end
    end
    n_cmp++;
    if (got_data.size() !== 128 || free_cnt !== 2) begin
      n_err++;
      $display("FAIL t6_counts: got words=%0d free=%0d, required 128 2", got_data.size(), free_cnt);
    end
  endtask

  task automatic test_async_reset();
    clear_mon();
    fill_exp(1);
    out_ready = 1'b1;
    pulse_full();
    wait_words(31, 200, "t4_pre");
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_en, out_valid, bank_free, busy, out_col_last, out_frm_last, rd_addr, out_data} !== '0) begin
      n_err++;
      $display("FAIL t4_async: got en=%b v=%b free=%b busy=%b cl=%b fl=%b addr=%0d data=%0d, required all 0",
               rd_en, out_valid, bank_free, busy, out_col_last, out_frm_last, rd_addr, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    clear_mon();
    pulse_full();
    n_cmp++;
    if (rd_en !== 1'b1 || rd_addr !== '0) begin
      n_err++;
      $display("FAIL t4_restart: got rd_en=%b addr=%0d, required 1 0", rd_en, rd_addr);
    end
    wait_words(64, 200, "t4");
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < got_data.size() && k < 64; k++) begin
      n_cmp++;
      if (got_data[k] !== exp_q[k] || got_col[k] !== ((k % 8) == 7) || got_frm[k] !== (k == 63)) begin
        n_err++;
        $display("FAIL t4_word[%0d]: got data=%0d cl=%b fl=%b, required data=%0d cl=%b fl=%b",
                 k, got_data[k], got_col[k], got_frm[k], exp_q[k], (k % 8) == 7, k == 63);
      end
    end
    n_cmp++;
    if (got_data.size() !== 64 || free_cnt !== 1) begin
      n_err++;
      $display("FAIL t4_counts: got words=%0d free=%0d, required 64 1", got_data.size(), free_cnt);
    end
  endtask

  task automatic test_row_major();
    int n_addr;
    int n_out;
    int n_free;
    n_addr = 0;
    n_out = 0;
    n_free = 0;
    rm_ready = 1'b1;
    @(posedge clk); #1 rm_full = 1'b1;
    @(posedge clk); #1 rm_full = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (rm_rd_en) begin
        n_cmp++;
        if (rm_rd_addr !== AW'(n_addr)) begin
          n_err++;
          $display("FAIL t5_addr[%0d]: got %0d, required %0d", n_addr, rm_rd_addr, n_addr);
        end
        n_addr++;
      end
      if (rm_valid && rm_ready) begin
        n_cmp++;
        if (rm_data !== W'(n_out * 3) || rm_col_last !== ((n_out % 8) == 7) || rm_frm_last !== (n_out == 63)) begin
          n_err++;
          $display("FAIL t5_word[%0d]: got data=%0d cl=%b fl=%b, required data=%0d cl=%b fl=%b",
                   n_out, rm_data, rm_col_last, rm_frm_last, n_out * 3, (n_out % 8) == 7, n_out == 63);
        end
        n_out++;
      end
      if (rm_free) n_free++;
    end
    n_cmp++;
    if (n_addr !== 64 || n_out !== 64 || n_free !== 1 || rm_busy !== 1'b0) begin
      n_err++;
      $display("FAIL t5_counts: got reads=%0d words=%0d free=%0d busy=%b, required 64 64 1 0",
               n_addr, n_out, n_free, rm_busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_rate();
    repeat (5) @(posedge clk);
    test_backpressure();
    repeat (5) @(posedge clk);
    test_back_to_back();
    repeat (5) @(posedge clk);
    test_drain_coincide();
    repeat (5) @(posedge clk);
    test_async_reset();
    repeat (5) @(posedge clk);
    test_row_major();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
